mdio_master_arb: RTL and testbench

Station-management master for the MDIO bus. It shares a single MDC/MDIO interface among N_REQ register-access requesters using round-robin arbitration. For each granted request it generates MDC and serializes one Clause-22 frame: preamble, ST, OP, PHYAD, REGAD, TA and 16 data bits. On reads it captures the PHY's 16-bit response. It sits between the management/config logic and the PHY-side MDIO receiver.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_master_arb_if.sv | 28 ++
 rtl/mdio_clk_gen.sv | 43 ++++
 rtl/mdio_master_arb.sv | 165 ++++++++++++++++
 tb/tb_mdio_master_arb.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, frame-field offsets and FSM states for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam int FRAME_BITS = 32;
  localparam int OFS_OP     = 2;
  localparam int OFS_PHY    = 4;
  localparam int OFS_REG    = 9;
  localparam int OFS_TA     = 14;
  localparam int OFS_DATA   = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Post-preamble frame, MSB first; TA and data are don't-care on reads (pad released).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                        input logic [4:0]  phy,
                                                        input logic [4:0]  regad,
                                                        input logic [15:0] data);
    return {ST_CODE, (wr ? OP_WR : OP_RD), phy, regad,
            (wr ? TA_WR : 2'b00), (wr ? data : 16'h0000)};
  endfunction

endpackage

// File: rtl/mdio_master_arb_if.sv
// Requester-side handshake plus MDIO pad signals of the arbitrated MDIO master.
interface mdio_master_arb_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    wr;
  logic [5*N_REQ-1:0]  phy_addr;
  logic [5*N_REQ-1:0]  reg_addr;
  logic [16*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [15:0]         rdata;
  logic                busy;
  logic                mdc;
  logic                mdio_out;
  logic                mdio_oe;
  logic                mdio_in;

  modport master (
    input  req, wr, phy_addr, reg_addr, wdata, mdio_in,
    output gnt, done, rdata, busy, mdc, mdio_out, mdio_oe
  );

  modport slave (
    output req, wr, phy_addr, reg_addr, wdata, mdio_in,
    input  gnt, done, rdata, busy, mdc, mdio_out, mdio_oe
  );
endinterface

// File: rtl/mdio_clk_gen.sv
// MDC divider: CLK_DIV clk cycles per half-period while run is high, held low otherwise.
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mdc,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int            CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          mdc_reg, mdc_next;
  logic          wrap;

  // Strobes flag the edge at the end of this cycle, where mdc will toggle.
  assign wrap     = run && (cnt_reg == CNT_MAX);
  assign rise_stb = wrap && !mdc_reg;
  assign fall_stb = wrap && mdc_reg;
  assign mdc      = mdc_reg;

  always_comb begin
    cnt_next = '0;
    mdc_next = 1'b0;
    if (run) begin
      cnt_next = wrap ? '0 : cnt_reg + 1'b1;
      mdc_next = wrap ? ~mdc_reg : mdc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
      mdc_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      mdc_reg <= mdc_next;
    end
  end
endmodule

// File: rtl/mdio_master_arb.sv
// Round-robin arbitrated Clause-22 MDIO master: one frame per grant, read data captured at frame end.
module mdio_master_arb
  import mdio_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input logic               clk,
  input logic               reset,
  mdio_master_arb_if.master bus
);
  localparam int         IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [6:0] LAST_BIT = 7'(PRE_LEN + FRAME_BITS - 1);

  state_t state_reg, state_next;
  logic [IW-1:0]         last_reg, last_next, owner_reg, owner_next, pick;
  logic [N_REQ-1:0]      gnt_reg, gnt_next, done_reg, done_next;
  logic                  wr_reg, wr_next;
  logic [FRAME_BITS-1:0] frame_reg, frame_next;
  logic [6:0]            bit_reg, bit_next;
  logic [15:0]           shift_reg, shift_next, rdata_reg, rdata_next;
  logic                  busy_reg, busy_next, out_reg, out_next, oe_reg, oe_next;
  logic                  rise_seen_reg, found, end_frame, run;
  logic                  mdc_w, rise_stb, fall_stb;

  logic [4:0]  phy_arr   [N_REQ];
  logic [4:0]  reg_arr   [N_REQ];
  logic [15:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign phy_arr[gi]   = bus.phy_addr[5*gi +: 5];
    assign reg_arr[gi]   = bus.reg_addr[5*gi +: 5];
    assign wdata_arr[gi] = bus.wdata[16*gi +: 16];
  end

  // Search starts one past the last grant and wraps.
  always_comb begin : p_rr
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int n = 1; n <= N_REQ; n++) begin
      idx = (int'(last_reg) + n) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // rise_seen_reg marks the first cycle mdc is high; the frame closes there on its last bit.
  assign end_frame = (state_reg == SHIFT) && rise_seen_reg && (bit_reg == LAST_BIT);
  assign run       = (state_reg == SHIFT) && !end_frame;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mdc      (mdc_w),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin : p_fsm
    int         k_cur, k_nxt;
    logic [4:0] sel;
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    gnt_next   = '0;
    done_next  = '0;
    wr_next    = wr_reg;
    frame_next = frame_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    rdata_next = rdata_reg;
    busy_next  = busy_reg;
    out_next   = out_reg;
    oe_next    = oe_reg;
    k_cur      = int'(bit_reg) - PRE_LEN;
    k_nxt      = k_cur + 1;
    sel        = 5'(FRAME_BITS - 1 - k_nxt);

    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = SHIFT;
          gnt_next   = N_REQ'(1) << pick;
          last_next  = pick;
          owner_next = pick;
          wr_next    = bus.wr[pick];
          frame_next = build_frame(bus.wr[pick], phy_arr[pick], reg_arr[pick], wdata_arr[pick]);
          bit_next   = '0;
          busy_next  = 1'b1;
          out_next   = 1'b1;
          oe_next    = 1'b1;
        end
      end
      SHIFT: begin
        if (rise_seen_reg && !wr_reg && k_cur >= OFS_DATA)
          shift_next = {shift_reg[14:0], bus.mdio_in};
        if (end_frame) begin
          state_next = DONE;
          done_next  = N_REQ'(1) << owner_reg;
          if (!wr_reg)
            rdata_next = {shift_reg[14:0], bus.mdio_in};
        end else if (fall_stb) begin
          bit_next = bit_reg + 7'd1;
          out_next = (k_nxt < 0) ? 1'b1 : frame_reg[sel];
          oe_next  = wr_reg || (k_nxt < OFS_TA);
        end
      end
      DONE: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        out_next   = 1'b0;
        oe_next    = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      last_reg      <= IW'(N_REQ - 1);
      owner_reg     <= '0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      wr_reg        <= 1'b0;
      frame_reg     <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      rdata_reg     <= '0;
      busy_reg      <= 1'b0;
      out_reg       <= 1'b0;
      oe_reg        <= 1'b0;
      rise_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_reg      <= last_next;
      owner_reg     <= owner_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      wr_reg        <= wr_next;
      frame_reg     <= frame_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      rdata_reg     <= rdata_next;
      busy_reg      <= busy_next;
      out_reg       <= out_next;
      oe_reg        <= oe_next;
      rise_seen_reg <= rise_stb;
    end
  end

  assign bus.gnt      = gnt_reg;
  assign bus.done     = done_reg;
  assign bus.rdata    = rdata_reg;
  assign bus.busy     = busy_reg;
  assign bus.mdc      = mdc_w;
  assign bus.mdio_out = out_reg;
  assign bus.mdio_oe  = oe_reg;
endmodule

// File: tb/tb_mdio_master_arb.sv
// Directed bench: dut_a uses default timing, dut_b the CLK_DIV=1 / PRE_LEN=1 corner.
module tb_mdio_master_arb;
  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  mdio_master_arb_if #(.N_REQ(2)) bus_a ();
  mdio_master_arb_if #(.N_REQ(2)) bus_b ();

  mdio_master_arb #(.N_REQ(2), .CLK_DIV(4), .PRE_LEN(32)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a.master));
  mdio_master_arb #(.N_REQ(2), .CLK_DIV(1), .PRE_LEN(1)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b.master));

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [1:0] ga_q[$];
  int         gc_q[$];
  logic       gb_q[$];
  int         dc_q[$];
  logic [1:0] bit_q[$];
  int         rise_a = 0, rise_b = 0, stuck_b = 0, gnt_long_a = 0;
  int         gnt_b_cyc = -1, done_b_cyc = -1;
  logic       mdc_a_prev = 1'b0, busy_a_prev = 1'b0, gnt_a_prev = 1'b0, mdc_b_prev = 1'b0;
  logic [15:0] phy_a = 16'h0000, phy_b = 16'h0000;

  function automatic logic phy_bit(input logic [15:0] d, input int k);
    return (k >= 16 && k <= 31) ? d[31-k] : 1'b1;
  endfunction

  // Monitor and PHY model: PHY drives the next data bit right after each mdc fall.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus_a.gnt != 2'b00) begin
      ga_q.push_back(bus_a.gnt);
      gc_q.push_back(cyc);
      gb_q.push_back(busy_a_prev);
      rise_a = 0;
      if (gnt_a_prev) gnt_long_a++;
    end
    if (bus_a.done != 2'b00) dc_q.push_back(cyc);
    if (bus_a.mdc && !mdc_a_prev) begin
      bit_q.push_back({bus_a.mdio_oe, bus_a.mdio_out});
      rise_a++;
    end
    if (!bus_a.mdc && mdc_a_prev) bus_a.mdio_in = phy_bit(phy_a, rise_a - 32);
    mdc_a_prev  = bus_a.mdc;
    busy_a_prev = bus_a.busy;
    gnt_a_prev  = (bus_a.gnt != 2'b00);

    if (bus_b.gnt != 2'b00) begin gnt_b_cyc = cyc; rise_b = 0; end
    if (bus_b.done != 2'b00) done_b_cyc = cyc;
    if (bus_b.busy && bus_b.gnt == 2'b00 && bus_b.done == 2'b00 && bus_b.mdc == mdc_b_prev)
      stuck_b++;
    if (bus_b.mdc && !mdc_b_prev) rise_b++;
    if (!bus_b.mdc && mdc_b_prev) bus_b.mdio_in = phy_bit(phy_b, rise_b - 1);
    mdc_b_prev = bus_b.mdc;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt_a(input string tag);
    int n = 0;
    while (bus_a.gnt == 2'b00 && n < 100) begin step(); n++; end
    check(tag, 64'(bus_a.gnt != 2'b00), 64'd1);
  endtask

  task automatic wait_done_a(input string tag, input int target);
    int n = 0;
    while (dc_q.size() < target && n < 3000) begin step(); n++; end
    check(tag, 64'(dc_q.size() >= target), 64'd1);
  endtask

  task automatic collect(output logic [63:0] o, output logic [63:0] e);
    o = '0;
    e = '0;
    for (int i = 0; i < bit_q.size() && i < 64; i++) begin
      o = {o[62:0], bit_q[i][0]};
      e = {e[62:0], bit_q[i][1]};
    end
  endtask

  initial begin
    logic [63:0] obs_out, obs_oe;
    int n, g0, d0;
    bus_a.req = '0; bus_a.wr = '0; bus_a.phy_addr = '0; bus_a.reg_addr = '0;
    bus_a.wdata = '0; bus_a.mdio_in = 1'b1;
    bus_b.req = '0; bus_b.wr = '0; bus_b.phy_addr = '0; bus_b.reg_addr = '0;
    bus_b.wdata = '0; bus_b.mdio_in = 1'b1;
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (3) step();

    check("rst_gnt",   64'(bus_a.gnt),      64'd0);
    check("rst_done",  64'(bus_a.done),     64'd0);
    check("rst_rdata", 64'(bus_a.rdata),    64'd0);
    check("rst_busy",  64'(bus_a.busy),     64'd0);
    check("rst_mdc",   64'(bus_a.mdc),      64'd0);
    check("rst_out",   64'(bus_a.mdio_out), 64'd0);
    check("rst_oe",    64'(bus_a.mdio_oe),  64'd0);
    check("rst_b_mdc", 64'(bus_b.mdc),      64'd0);
    reset_a = 1'b1;
    reset_b = 1'b1;
    step();

    // Corner: CLK_DIV=1, PRE_LEN=1 read on dut_b.
    phy_b = 16'h3C5A;
    bus_b.wr = 2'b00; bus_b.phy_addr[4:0] = 5'h03; bus_b.reg_addr[4:0] = 5'h04;
    bus_b.req = 2'b01;
    n = 0;
    while (bus_b.gnt == 2'b00 && n < 20) begin step(); n++; end
    bus_b.req = 2'b00;
    n = 0;
    while (done_b_cyc < 0 && n < 200) begin step(); n++; end
    check("b_latency", 64'(done_b_cyc - gnt_b_cyc), 64'd66);
    check("b_rdata",   64'(bus_b.rdata),            64'h3C5A);
    check("b_mdc_toggle_stuck", 64'(stuck_b),       64'd0);
    check("b_rises",   64'(rise_b),                 64'd33);

    // Write on requester 0.
    bit_q.delete();
    d0 = dc_q.size();
    bus_a.wr = 2'b01; bus_a.phy_addr[4:0] = 5'h01; bus_a.reg_addr[4:0] = 5'h02;
    bus_a.wdata[15:0] = 16'h4546;
    bus_a.req = 2'b01;
    wait_gnt_a("wr_gnt_wait");
    bus_a.req = 2'b00;
    wait_done_a("wr_done_wait", d0 + 1);
    check("wr_gnt",     64'(ga_q[$]),           64'd1);
    check("wr_done",    64'(bus_a.done),        64'd1);
    check("wr_latency", 64'(dc_q[$] - gc_q[$]), 64'd509);
    check("wr_nbits",   64'(bit_q.size()),      64'd64);
    collect(obs_out, obs_oe);
    check("wr_bits",    obs_out, {32'hFFFF_FFFF, 32'h508A_4546});
    check("wr_oe",      obs_oe,  64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wr_busy_after", 64'(bus_a.busy),    64'd0);
    check("wr_oe_after",   64'(bus_a.mdio_oe), 64'd0);

    // Read on requester 1.
    bit_q.delete();
    d0 = dc_q.size();
    phy_a = 16'hA5C3;
    bus_a.wr = 2'b00; bus_a.phy_addr[9:5] = 5'h1F; bus_a.reg_addr[9:5] = 5'h00;
    bus_a.req = 2'b10;
    wait_gnt_a("rd_gnt_wait");
    bus_a.req = 2'b00;
    wait_done_a("rd_done_wait", d0 + 1);
    check("rd_gnt",     64'(ga_q[$]),           64'd2);
    check("rd_done",    64'(bus_a.done),        64'd2);
    check("rd_rdata",   64'(bus_a.rdata),       64'hA5C3);
    check("rd_latency", 64'(dc_q[$] - gc_q[$]), 64'd509);
    collect(obs_out, obs_oe);
    check("rd_hdr_bits", 64'(obs_out[63:18]), {18'd0, 32'hFFFF_FFFF, 14'b01_10_11111_00000});
    check("rd_oe",       obs_oe, 64'hFFFF_FFFF_FFFC_0000);

    // Contention: both requesters held high.
    g0 = ga_q.size();
    d0 = dc_q.size();
    bus_a.wr = 2'b11;
    bus_a.req = 2'b11;
    n = 0;
    while (ga_q.size() < g0 + 4 && n < 3000) begin step(); n++; end
    bus_a.req = 2'b00;
    wait_done_a("cont_done_wait", d0 + 4);
    check("cont_ngnt", 64'(ga_q.size() - g0), 64'd4);
    for (int i = 0; i < 4 && g0 + i < ga_q.size(); i++) begin
      check($sformatf("cont_gnt%0d", i),      64'(ga_q[g0+i]), (i % 2 == 0) ? 64'd1 : 64'd2);
      check($sformatf("cont_idle_pre%0d", i), 64'(gb_q[g0+i]), 64'd0);
    end
    check("cont_gnt_one_cycle", 64'(gnt_long_a),  64'd0);
    check("cont_rdata_kept",    64'(bus_a.rdata), 64'hA5C3);

    // Reset mid-frame at bit 40.
    d0 = dc_q.size();
    bus_a.wr = 2'b01;
    bus_a.req = 2'b01;
    wait_gnt_a("rst_gnt_wait");
    bus_a.req = 2'b00;
    n = 0;
    while (rise_a < 41 && n < 400) begin step(); n++; end
    check("rst_reach_b40", 64'(rise_a), 64'd41);
    reset_a = 1'b0;
    step();
    check("midrst_mdc",  64'(bus_a.mdc),      64'd0);
    check("midrst_oe",   64'(bus_a.mdio_oe),  64'd0);
    check("midrst_busy", 64'(bus_a.busy),     64'd0);
    check("midrst_out",  64'(bus_a.mdio_out), 64'd0);
    reset_a = 1'b1;
    repeat (300) step();
    check("midrst_no_done", 64'(dc_q.size()), 64'(d0));

    // Fresh accept after reset, with a one-cycle req1 pulse while busy.
    g0 = ga_q.size();
    bus_a.req = 2'b01;
    wait_gnt_a("post_gnt_wait");
    bus_a.req = 2'b00;
    repeat (10) step();
    bus_a.req = 2'b10;
    step();
    bus_a.req = 2'b00;
    wait_done_a("post_done_wait", d0 + 1);
    repeat (20) step();
    check("post_gnt",     64'(ga_q[g0]),          64'd1);
    check("post_latency", 64'(dc_q[$] - gc_q[$]), 64'd509);
    check("withdrawn_ngnt", 64'(ga_q.size() - g0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
